data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 16x8 data memory between the CPU core (port 0) and the I/O/DMA engine (port 1). It accepts per-port read/write requests with a req/gnt handshake, drives the memory's `ip`, `w_add`, `r_add`, `rw` inputs, and returns read data with a per-port valid pulse. It sits between the requesters and `data_mem`, and is the only block allowed to drive the memory's control inputs.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/data_mem.sv | 35 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/data_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the data-memory arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default widths of the 16x8 data memory
//   arb_state_t             : arbiter sequencer states
//   PORT_CPU / PORT_IO      : requester port indices
//   port_onehot()           : port index -> one-hot 2-bit vector
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // IDLE: no access in flight. BUSY: a grant was issued at the last edge and
  // the memory performs that access at the coming negedge.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// Single-port-style 16x8 data memory shared by the CPU and the I/O engine.
// The access happens on the falling clock edge: rw=0 writes ip to w_add,
// rw=1 reads r_add into op. The contents are not reset.
//   clk   : clock (accesses on negedge)
//   ip    : write data
//   w_add : write address
//   r_add : read address
//   rw    : 0 = write, 1 = read
//   op    : registered read data
// ---------------------------------------------------------------------------
module data_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] ip,
  input  logic [ADDR_W-1:0] w_add,
  input  logic [ADDR_W-1:0] r_add,
  input  logic              rw,
  output logic [DATA_W-1:0] op
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(negedge clk) begin
    if (!rw) begin
      mem[w_add] <= ip;
    end else begin
      op <= mem[r_add];
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way winner selection.
//   eligible  : per-port eligible requests
//   last      : port granted most recently
//   any_win   : at least one port is eligible
//   winner    : index of the selected port (valid when any_win)
// FIXED_PRI=1 makes port 0 win every tie; otherwise a tie goes to the port
// that was not granted last.
// ---------------------------------------------------------------------------
module rr_arb2
  import mem_ctrl_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       any_win,
  output logic       winner
);

  always_comb begin
    any_win = |eligible;
    winner  = PORT_CPU;
    case (eligible)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_IO;
      2'b11:   winner = (FIXED_PRI != 0) ? PORT_CPU : ~last;
      default: winner = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the 16x8 data memory between the CPU core (port 0) and the I/O/DMA
// engine (port 1). Grants one request per edge, drives the memory controls
// and returns read data with a per-port valid pulse one edge after the grant.
//   clk            : system clock, all state on posedge
//   reset          : asynchronous, active-low reset
//   req, we        : per-port request / write-enable
//   addr0, addr1   : per-port address
//   wdata0, wdata1 : per-port write data
//   gnt            : one-hot, one-cycle grant pulse
//   rvalid         : one-cycle read-valid pulse, per port
//   rdata          : shared read data, qualified by rvalid
//   mem_ip, mem_w_add, mem_r_add, mem_rw : memory controls (rw 0 = write)
//   mem_op         : memory read data
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W    = mem_ctrl_pkg::DEF_DATA_W,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_ip,
  output logic [ADDR_W-1:0] mem_w_add,
  output logic [ADDR_W-1:0] mem_r_add,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_op
);

  arb_state_t        state_q, state_d;
  logic [1:0]        eligible;
  logic              any_win;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ip_d;
  logic [DATA_W-1:0] rdata_d;
  logic [1:0]        gnt_d, rvalid_d;
  logic              rw_d;
  logic              tag_q, tag_d;
  logic              rd_pend_q, rd_pend_d;
  logic              last_q, last_d;

  // A port whose grant is high this cycle is masked out, so a request that is
  // still held while the requester samples gnt is never granted twice.
  assign eligible = req & ~gnt;

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_rr_arb2 (
    .eligible(eligible),
    .last    (last_q),
    .any_win (any_win),
    .winner  (winner)
  );

  assign sel_we    = winner ? we[1]  : we[0];
  assign sel_addr  = winner ? addr1  : addr0;
  assign sel_wdata = winner ? wdata1 : wdata0;

  // Read and write share one address register; the memory sees it on both
  // address inputs.
  assign mem_w_add = addr_q;
  assign mem_r_add = addr_q;

  // Next-state and next-output logic. With no grant mem_rw returns to read,
  // because the memory writes on any negedge that sees rw=0. Address and
  // write data simply hold. A read granted at the last edge has its data
  // captured from the memory now, since the memory read at the negedge in
  // between.
  always_comb begin
    state_d   = IDLE;
    gnt_d     = '0;
    rw_d      = 1'b1;
    addr_d    = addr_q;
    ip_d      = mem_ip;
    tag_d     = tag_q;
    rd_pend_d = 1'b0;
    last_d    = last_q;
    rvalid_d  = '0;
    rdata_d   = rdata;

    if (any_win) begin
      state_d   = BUSY;
      gnt_d     = port_onehot(winner);
      rw_d      = ~sel_we;
      addr_d    = sel_addr;
      ip_d      = sel_wdata;
      tag_d     = winner;
      rd_pend_d = ~sel_we;
      last_d    = winner;
    end

    if ((state_q == BUSY) && rd_pend_q) begin
      rvalid_d = port_onehot(tag_q);
      rdata_d  = mem_op;
    end
  end

  // State and output registers. Reset drops any in-flight read and forces the
  // memory to read so no spurious write can occur.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_rw    <= 1'b1;
      addr_q    <= '0;
      mem_ip    <= '0;
      tag_q     <= PORT_CPU;
      rd_pend_q <= 1'b0;
      last_q    <= PORT_IO;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      mem_rw    <= rw_d;
      addr_q    <= addr_d;
      mem_ip    <= ip_d;
      tag_q     <= tag_d;
      rd_pend_q <= rd_pend_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Two arbiters (round-robin and fixed-priority) share the same requester
// inputs, each driving its own data_mem. A transaction-level reference model
// follows both; a vector table and a reset sequence cover the corner cases.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;

  logic [1:0] gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0] rdata_a, ip_a, op_a, rdata_b, ip_b, op_b;
  logic [3:0] wadd_a, radd_a, wadd_b, radd_b;
  logic       rw_a, rw_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRI(0)) u_dut_a (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_ip(ip_a), .mem_w_add(wadd_a), .mem_r_add(radd_a),
    .mem_rw(rw_a), .mem_op(op_a)
  );

  data_mem #(.ADDR_W(4), .DATA_W(8)) u_mem_a (
    .clk(clk), .ip(ip_a), .w_add(wadd_a), .r_add(radd_a), .rw(rw_a), .op(op_a)
  );

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRI(1)) u_dut_b (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_ip(ip_b), .mem_w_add(wadd_b), .mem_r_add(radd_b),
    .mem_rw(rw_b), .mem_op(op_b)
  );

  data_mem #(.ADDR_W(4), .DATA_W(8)) u_mem_b (
    .clk(clk), .ip(ip_b), .w_add(wadd_b), .r_add(radd_b), .rw(rw_b), .op(op_b)
  );

  // Reference model: each grant is one access applied in order to an array;
  // a read's value is delivered at the following edge.
  logic [1:0] m_gnt [2];
  logic       m_last [2];
  logic       m_pend [2];
  logic       m_ptag [2];
  logic [7:0] m_pdata [2];
  logic [1:0] m_rvalid [2];
  logic [7:0] m_rdata [2];
  logic       m_rw [2];
  logic [3:0] m_addr [2];
  logic [7:0] m_ip [2];
  logic [7:0] m_mem [2][16];

  function automatic logic [7:0] init_val(input int a);
    return 8'(8'h30 + a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset(input int i);
    m_gnt[i] = '0; m_last[i] = 1'b1; m_pend[i] = 1'b0; m_ptag[i] = 1'b0;
    m_pdata[i] = '0; m_rvalid[i] = '0; m_rdata[i] = '0; m_rw[i] = 1'b1;
    m_addr[i] = '0; m_ip[i] = '0;
  endtask

  task automatic modelStep(input int i, input bit fixed, input logic [1:0] r, input logic [1:0] w,
                           input logic [3:0] a0, input logic [3:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0] elig;
    int win;
    logic [3:0] a;
    logic [7:0] d;
    m_rvalid[i] = '0;
    if (m_pend[i]) begin
      m_rvalid[i] = m_ptag[i] ? 2'b10 : 2'b01;
      m_rdata[i] = m_pdata[i];
    end
    elig = r & ~m_gnt[i];
    win = -1;
    if (elig == 2'b11) win = fixed ? 0 : (m_last[i] ? 0 : 1);
    else if (elig[0]) win = 0;
    else if (elig[1]) win = 1;
    m_pend[i] = 1'b0;
    m_gnt[i] = '0;
    m_rw[i] = 1'b1;
    if (win >= 0) begin
      a = (win == 1) ? a1 : a0;
      d = (win == 1) ? d1 : d0;
      m_gnt[i] = (win == 1) ? 2'b10 : 2'b01;
      m_last[i] = (win == 1);
      m_addr[i] = a;
      m_ip[i] = d;
      m_rw[i] = ~w[win];
      if (w[win]) begin
        m_mem[i][a] = d;
      end else begin
        m_pend[i] = 1'b1;
        m_ptag[i] = (win == 1);
        m_pdata[i] = m_mem[i][a];
      end
    end
  endtask

  task automatic checkDut(input int i, input logic [1:0] g, input logic [1:0] v, input logic [7:0] rd,
                          input logic rw, input logic [3:0] wa, input logic [3:0] ra, input logic [7:0] ip);
    string p;
    p = (i == 0) ? "A" : "B";
    checkOutput({p, " model gnt"}, 32'(g), 32'(m_gnt[i]));
    checkOutput({p, " model rvalid"}, 32'(v), 32'(m_rvalid[i]));
    checkOutput({p, " model rdata"}, 32'(rd), 32'(m_rdata[i]));
    checkOutput({p, " model mem_rw"}, 32'(rw), 32'(m_rw[i]));
    checkOutput({p, " model w_add"}, 32'(wa), 32'(m_addr[i]));
    checkOutput({p, " model r_add"}, 32'(ra), 32'(m_addr[i]));
    checkOutput({p, " model mem_ip"}, 32'(ip), 32'(m_ip[i]));
  endtask

  // Every edge: step (or reset) the model with the inputs seen at the edge,
  // then compare both DUTs shortly after the edge.
  always @(posedge clk) begin : ref_check
    logic [1:0] sr, sw;
    logic [3:0] sa0, sa1;
    logic [7:0] sd0, sd1;
    logic srst;
    sr = req; sw = we; sa0 = addr0; sa1 = addr1; sd0 = wdata0; sd1 = wdata1; srst = reset;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!srst) modelReset(i);
      else modelStep(i, (i == 1), sr, sw, sa0, sa1, sd0, sd1);
    end
    checkDut(0, gnt_a, rvalid_a, rdata_a, rw_a, wadd_a, radd_a, ip_a);
    checkDut(1, gnt_b, rvalid_b, rdata_b, rw_b, wadd_b, radd_b, ip_b);
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [3:0] x0, input logic [3:0] x1,
                               input logic [7:0] y0, input logic [7:0] y1);
    req = r; we = w; addr0 = x0; addr1 = x1; wdata0 = y0; wdata1 = y1;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [1:0] r, w;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] g_a, g_b, v_a, v_b;
    logic [7:0] rd_a, rd_b;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [1:0] nr, nw;
    logic [3:0] na0, na1;
    logic [7:0] nd0, nd1;

    // Write 5A to 3, read it from port 1; tie of reads; port 1 streaming
    // reads of 0..3; write FF to 15 and read it at once; RR vs fixed tie.
    vecs.push_back('{2'b01, 2'b01, 4'd3, 4'd0, 8'h5A, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd3, 4'd3, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, 8'h5A, 8'h5A});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 2'b10, 2'b01, 2'b01, init_val(1), init_val(1)});
    vecs.push_back('{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b01, 2'b10, 2'b10, init_val(2), init_val(2)});
    vecs.push_back('{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 2'b10, 2'b01, 2'b01, init_val(1), init_val(1)});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, init_val(2), init_val(2)});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, init_val(0), init_val(0)});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd2, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, init_val(1), init_val(1)});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd2, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, init_val(2), init_val(2)});
    vecs.push_back('{2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, 8'h5A, 8'h5A});
    vecs.push_back('{2'b01, 2'b01, 4'd15, 4'd0, 8'hFF, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 2'b00, 4'd15, 4'd15, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 2'b10, 8'hFF, 8'hFF});
    vecs.push_back('{2'b01, 2'b00, 4'd4, 4'd0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b01, init_val(4), init_val(4)});
    vecs.push_back('{2'b11, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00});
    vecs.push_back('{2'b11, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 2'b01, 2'b10, 2'b10, 2'b01, init_val(6), init_val(5)});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 2'b10, init_val(5), init_val(6)});
    vecs.push_back('{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset gnt", 32'(gnt_a), 32'h0);
    checkOutput("reset mem_rw", 32'(rw_a), 32'h1);
    checkOutput("reset rdata", 32'(rdata_a), 32'h0);
    reset = 1'b1;

    // Fill both memories with known contents through port 0.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(2'b01, 2'b01, 4'(a), 4'd0, init_val(a), 8'h00);
      checkOutput("init gnt", 32'(gnt_a), 32'h1);
      applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    end

    // Ten idle cycles: no grant, no write, memory untouched.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      checkOutput("idle gnt", 32'(gnt_a), 32'h0);
      checkOutput("idle mem_rw", 32'(rw_a), 32'h1);
    end
    for (int a = 0; a < 16; a++) begin
      checkOutput("idle mem A", 32'(u_mem_a.mem[a]), 32'(init_val(a)));
      checkOutput("idle mem B", 32'(u_mem_b.mem[a]), 32'(init_val(a)));
    end

    // Directed vector table.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].r, vecs[k].w, vecs[k].a0, vecs[k].a1, vecs[k].d0, vecs[k].d1);
      checkOutput($sformatf("vec%0d gnt A", k), 32'(gnt_a), 32'(vecs[k].g_a));
      checkOutput($sformatf("vec%0d gnt B", k), 32'(gnt_b), 32'(vecs[k].g_b));
      checkOutput($sformatf("vec%0d rvalid A", k), 32'(rvalid_a), 32'(vecs[k].v_a));
      checkOutput($sformatf("vec%0d rvalid B", k), 32'(rvalid_b), 32'(vecs[k].v_b));
      if (vecs[k].v_a != 2'b00)
        checkOutput($sformatf("vec%0d rdata A", k), 32'(rdata_a), 32'(vecs[k].rd_a));
      if (vecs[k].v_b != 2'b00)
        checkOutput($sformatf("vec%0d rdata B", k), 32'(rdata_b), 32'(vecs[k].rd_b));
    end

    // Reset asserted during the grant cycle of a read: the read is dropped.
    applyStimulus(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
    checkOutput("rst seq gnt", 32'(gnt_a), 32'h1);
    checkOutput("rst seq rw", 32'(rw_a), 32'h1);
    reset = 1'b0;
    req = 2'b00;
    #1;
    checkOutput("rst async gnt", 32'(gnt_a), 32'h0);
    checkOutput("rst async rw", 32'(rw_a), 32'h1);
    checkOutput("rst async w_add", 32'(wadd_a), 32'h0);
    checkOutput("rst async r_add", 32'(radd_a), 32'h0);
    checkOutput("rst async mem_ip", 32'(ip_a), 32'h0);
    checkOutput("rst async rdata", 32'(rdata_a), 32'h0);
    @(posedge clk);
    #2;
    checkOutput("rst dropped rvalid A", 32'(rvalid_a), 32'h0);
    checkOutput("rst dropped rvalid B", 32'(rvalid_b), 32'h0);
    checkOutput("rst hold rw", 32'(rw_a), 32'h1);
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    checkOutput("post rst rvalid", 32'(rvalid_a), 32'h0);

    // Random traffic: requesters hold until granted, may withdraw, and may
    // present a new request in the cycle after their grant.
    nr = 2'b00; nw = 2'b00; na0 = '0; na1 = '0; nd0 = '0; nd1 = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (nr[p] && !m_gnt[0][p]) begin
          if ($urandom_range(0, 19) == 0) nr[p] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          nr[p] = 1'b1;
          nw[p] = 1'($urandom_range(0, 1));
          if (p == 0) begin
            na0 = 4'($urandom_range(0, 15));
            nd0 = 8'($urandom_range(0, 255));
          end else begin
            na1 = 4'($urandom_range(0, 15));
            nd1 = 8'($urandom_range(0, 255));
          end
        end else begin
          nr[p] = 1'b0;
        end
      end
      applyStimulus(nr, nw, na0, na1, nd0, nd1);
    end

    repeat (3) applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
